// File: rtl/data_sync_arb_pkg.sv
// Shared types, defaults and width helpers for the DATA_SYNC transmit arbiter.
package data_sync_arb_pkg;

    // Arbiter FSM: wait for a request, hold bus_enable, then keep the bus frozen.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GUARD = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_BUS_WIDTH    = 8;
    localparam int DEF_HOLD_CYCLES  = 3;
    localparam int DEF_GUARD_CYCLES = 4;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width of the shared hold/guard down-counter.
    function automatic int cnt_width(input int hold, input int guard);
        int m;
        m = (hold > guard) ? hold : guard;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/data_sync_rr_picker.sv
// Combinational winner select for the DATA_SYNC transmit arbiter.
// Default: round-robin scan starting at i_ptr.
// Macro DSA_FIXED_PRIO_EN: fixed priority (lowest index wins), no pointer input.
module data_sync_rr_picker
    import data_sync_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]               i_req,
`ifndef DSA_FIXED_PRIO_EN
    input  logic [idx_width(NUM_REQ)-1:0]    i_ptr,
`endif
    output logic [idx_width(NUM_REQ)-1:0]    o_winner,
    output logic                             o_valid
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int SUM_W = IDX_W + 1;

    // w_cand_idx[k] is the requester examined k-th in the scan order.
    logic [IDX_W-1:0]   w_cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] w_cand_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
`ifdef DSA_FIXED_PRIO_EN
            assign w_cand_idx[gi] = IDX_W'(gi);
`else
            logic [SUM_W-1:0] w_sum;
            // (ptr + k) mod NUM_REQ without a divider: both terms are < NUM_REQ.
            assign w_sum          = {1'b0, i_ptr} + SUM_W'(gi);
            assign w_cand_idx[gi] = (w_sum >= SUM_W'(NUM_REQ)) ?
                                    IDX_W'(w_sum - SUM_W'(NUM_REQ)) : IDX_W'(w_sum);
`endif
            assign w_cand_hit[gi] = i_req[w_cand_idx[gi]];
        end
    endgenerate

    // First hit in scan order wins; later candidates are overridden by earlier ones.
    always_comb begin
        o_winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_cand_hit[k]) begin
                o_winner = w_cand_idx[k];
            end
        end
        o_valid = |w_cand_hit;
    end

endmodule

// File: rtl/data_sync_tx_arbiter.sv
// Source-domain scheduler sharing one DATA_SYNC crossing channel among NUM_REQ
// requesters. A grant latches the winner's word onto o_unsync_bus, raises
// o_bus_enable for HOLD_CYCLES, then keeps the bus frozen for GUARD_CYCLES so
// the destination synchronizer can detect the enable and capture the data.
// Macro DSA_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module data_sync_tx_arbiter
    import data_sync_arb_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int BUS_WIDTH    = DEF_BUS_WIDTH,
    parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
    parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [NUM_REQ-1:0]               i_req,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]     i_req_data,
    output logic [NUM_REQ-1:0]               o_ack,
    output logic [idx_width(NUM_REQ)-1:0]    o_grant_id,
    output logic                             o_busy,
    output logic [BUS_WIDTH-1:0]             o_unsync_bus,
    output logic                             o_bus_enable
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = cnt_width(HOLD_CYCLES, GUARD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);

    arb_state_e          r_state,    w_state_next;
    logic [CNT_W-1:0]    r_cnt,      w_cnt_next;
    logic [NUM_REQ-1:0]  r_ack,      w_ack_next;
    logic [IDX_W-1:0]    r_grant_id, w_grant_id_next;
    logic                r_busy,     w_busy_next;
    logic [BUS_WIDTH-1:0] r_bus,     w_bus_next;
    logic                r_bus_en,   w_bus_en_next;

    logic [IDX_W-1:0]    w_winner;
    logic                w_win_valid;
    logic [BUS_WIDTH-1:0] w_req_word [NUM_REQ];

`ifndef DSA_FIXED_PRIO_EN
    logic [IDX_W-1:0]    r_ptr,      w_ptr_next;
`endif

    // Split the flat request data bus into one word per requester.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_word
            assign w_req_word[gi] = i_req_data[gi*BUS_WIDTH +: BUS_WIDTH];
        end
    endgenerate

    data_sync_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_req    (i_req),
`ifndef DSA_FIXED_PRIO_EN
        .i_ptr    (r_ptr),
`endif
        .o_winner (w_winner),
        .o_valid  (w_win_valid)
    );

    // Next-state and next-output logic; everything defaults to holding its value.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_ack_next      = '0;
        w_grant_id_next = r_grant_id;
        w_bus_next      = r_bus;
        w_bus_en_next   = r_bus_en;
`ifndef DSA_FIXED_PRIO_EN
        w_ptr_next      = r_ptr;
`endif
        case (r_state)
            IDLE: begin
                w_bus_en_next = 1'b0;
                if (w_win_valid) begin
                    w_state_next    = DRIVE;
                    w_cnt_next      = HOLD_LOAD;
                    w_ack_next      = NUM_REQ'(1) << w_winner;
                    w_grant_id_next = w_winner;
                    w_bus_next      = w_req_word[w_winner];
                    w_bus_en_next   = 1'b1;
`ifndef DSA_FIXED_PRIO_EN
                    w_ptr_next      = (w_winner == LAST_IDX) ? '0 : w_winner + IDX_W'(1);
`endif
                end
            end
            DRIVE: begin
                if (r_cnt == '0) begin
                    w_state_next  = GUARD;
                    w_cnt_next    = GUARD_LOAD;
                    w_bus_en_next = 1'b0;
                end else begin
                    w_cnt_next    = r_cnt - CNT_W'(1);
                    w_bus_en_next = 1'b1;
                end
            end
            GUARD: begin
                w_bus_en_next = 1'b0;
                if (r_cnt == '0) begin
                    w_state_next = IDLE;
                end else begin
                    w_cnt_next   = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_next  = IDLE;
                w_bus_en_next = 1'b0;
            end
        endcase
        w_busy_next = (w_state_next != IDLE);
    end

    // FSM state, down-counter and arbitration pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
`ifndef DSA_FIXED_PRIO_EN
            r_ptr   <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
`ifndef DSA_FIXED_PRIO_EN
            r_ptr   <= w_ptr_next;
`endif
        end
    end

    // Registered channel and handshake outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ack      <= '0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
            r_bus      <= '0;
            r_bus_en   <= 1'b0;
        end else begin
            r_ack      <= w_ack_next;
            r_grant_id <= w_grant_id_next;
            r_busy     <= w_busy_next;
            r_bus      <= w_bus_next;
            r_bus_en   <= w_bus_en_next;
        end
    end

    assign o_ack        = r_ack;
    assign o_grant_id   = r_grant_id;
    assign o_busy       = r_busy;
    assign o_unsync_bus = r_bus;
    assign o_bus_enable = r_bus_en;

endmodule

// File: tb/tb_data_sync_tx_arbiter.sv
// Self-checking bench for data_sync_tx_arbiter: cycle vector table, round-robin
// scoreboard, reset abort, and end-to-end transfer through a DATA_SYNC model.
module tb_data_sync_tx_arbiter;

    logic        clk = 1'b0;
    logic        dclk = 1'b0;
    logic        rst_n;

    // Default-parameter instance
    logic [3:0]  req0;
    logic [31:0] req_data0;
    logic [3:0]  ack0;
    logic [1:0]  gid0;
    logic        busy0;
    logic [7:0]  bus0;
    logic        en0;

    // Instance sized legally for a 3x slower destination clock
    logic [3:0]  req1;
    logic [31:0] req_data1;
    logic [3:0]  ack1;
    logic [1:0]  gid1;
    logic        busy1;
    logic [7:0]  bus1;
    logic        en1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    initial begin
        #2;
        forever #15 dclk = ~dclk;
    end

    data_sync_tx_arbiter dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req0), .i_req_data(req_data0),
        .o_ack(ack0), .o_grant_id(gid0), .o_busy(busy0),
        .o_unsync_bus(bus0), .o_bus_enable(en0)
    );

    data_sync_tx_arbiter #(
        .NUM_REQ(4), .BUS_WIDTH(8), .HOLD_CYCLES(10), .GUARD_CYCLES(13)
    ) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req1), .i_req_data(req_data1),
        .o_ack(ack1), .o_grant_id(gid1), .o_busy(busy1),
        .o_unsync_bus(bus1), .o_bus_enable(en1)
    );

    // DATA_SYNC model, NUM_STAGES=2, destination domain
    logic [2:0] ds_sync;
    logic       ds_pulse;
    logic [7:0] ds_bus;
    always @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            ds_sync  <= '0;
            ds_pulse <= 1'b0;
            ds_bus   <= '0;
        end else begin
            ds_sync  <= {ds_sync[1:0], en1};
            ds_pulse <= ds_sync[1] & ~ds_sync[2];
            if (ds_sync[1] & ~ds_sync[2]) ds_bus <= bus1;
        end
    end

    logic [7:0] obs_word [8];
    int         obs_cnt = 0;
    always @(negedge dclk) begin
        if (ds_pulse && obs_cnt < 8) begin
            obs_word[obs_cnt] <= ds_bus;
            obs_cnt           <= obs_cnt + 1;
        end
    end

    typedef struct {
        logic [3:0] req;
        logic [7:0] d2;
        logic [3:0] ack;
        logic       en;
        logic       busy;
        logic [1:0] gid;
        logic [7:0] bus;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];
    int   exp_q [$];
    logic [7:0] e2e_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic [3:0] r, input logic [7:0] d,
                        input logic [3:0] a, input logic e, input logic b,
                        input logic [1:0] g, input logic [7:0] w);
        vecs[i] = '{req: r, d2: d, ack: a, en: e, busy: b, gid: g, bus: w};
    endtask

    task automatic wait_idle(input string nm);
        for (int c = 0; c < 20 && busy0; c++) begin
            @(posedge clk); #1;
        end
        chk(nm, {31'd0, busy0}, 32'd0);
    endtask

    function automatic logic [7:0] slot0(input int idx);
        return req_data0[idx*8 +: 8];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, last, grants, exp_id, idx, got;
        logic [3:0] prev_ack;
        logic [7:0] words [4];
        int         order [4];

        // Single request to 1, then data-freeze and withdrawal on requester 2/3
        setv(0,  4'b0010, 8'h11, 4'b0010, 1, 1, 2'd1, 8'hA5);
        setv(1,  4'b0000, 8'h11, 4'b0000, 1, 1, 2'd1, 8'hA5);
        setv(2,  4'b0000, 8'h11, 4'b0000, 1, 1, 2'd1, 8'hA5);
        setv(3,  4'b0000, 8'h11, 4'b0000, 0, 1, 2'd1, 8'hA5);
        setv(4,  4'b0000, 8'h11, 4'b0000, 0, 1, 2'd1, 8'hA5);
        setv(5,  4'b0000, 8'h11, 4'b0000, 0, 1, 2'd1, 8'hA5);
        setv(6,  4'b0000, 8'h11, 4'b0000, 0, 1, 2'd1, 8'hA5);
        setv(7,  4'b0000, 8'h11, 4'b0000, 0, 0, 2'd0, 8'h00);
        setv(8,  4'b0100, 8'h11, 4'b0100, 1, 1, 2'd2, 8'h11);
        setv(9,  4'b0000, 8'h22, 4'b0000, 1, 1, 2'd2, 8'h11);
        setv(10, 4'b0000, 8'h22, 4'b0000, 1, 1, 2'd2, 8'h11);
        setv(11, 4'b0000, 8'h22, 4'b0000, 0, 1, 2'd2, 8'h11);
        setv(12, 4'b1000, 8'h22, 4'b0000, 0, 1, 2'd2, 8'h11);
        setv(13, 4'b1000, 8'h22, 4'b0000, 0, 1, 2'd2, 8'h11);
        setv(14, 4'b1000, 8'h22, 4'b0000, 0, 1, 2'd2, 8'h11);
        setv(15, 4'b0000, 8'h22, 4'b0000, 0, 0, 2'd0, 8'h00);
        setv(16, 4'b0000, 8'h22, 4'b0000, 0, 0, 2'd0, 8'h00);

        rst_n     = 1'b0;
        req0      = '0;
        req1      = '0;
        req_data0 = {8'hC3, 8'h11, 8'hA5, 8'h3C};
        req_data1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", {28'd0, ack0}, 32'd0);
        chk("rst_en", {31'd0, en0}, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_bus", {24'd0, bus0}, 32'd0);
        chk("rst_gid", {30'd0, gid0}, 32'd0);
        rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < NV; i++) begin
            req0      = vecs[i].req;
            req_data0 = {8'hC3, vecs[i].d2, 8'hA5, 8'h3C};
            @(posedge clk); #1;
            chk($sformatf("vec%0d_ack", i), {28'd0, ack0}, {28'd0, vecs[i].ack});
            chk($sformatf("vec%0d_en", i), {31'd0, en0}, {31'd0, vecs[i].en});
            chk($sformatf("vec%0d_busy", i), {31'd0, busy0}, {31'd0, vecs[i].busy});
            if (vecs[i].busy) begin
                chk($sformatf("vec%0d_gid", i), {30'd0, gid0}, {30'd0, vecs[i].gid});
                chk($sformatf("vec%0d_bus", i), {24'd0, bus0}, {24'd0, vecs[i].bus});
            end
            $display("vec %0d req=%b ack=%b en=%b busy=%b gid=%0d bus=%h",
                     i, vecs[i].req, ack0, en0, busy0, gid0, bus0);
        end

        // Reset mid-DRIVE: outputs clear asynchronously, pointer restarts at 0
        req0 = 4'b0100;
        @(posedge clk); #1;
        chk("abort_grant", {28'd0, ack0}, 32'h4);
        req0 = 4'b1010;
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_ack", {28'd0, ack0}, 32'd0);
        chk("abort_en", {31'd0, en0}, 32'd0);
        chk("abort_busy", {31'd0, busy0}, 32'd0);
        chk("abort_bus", {24'd0, bus0}, 32'd0);
        chk("abort_gid", {30'd0, gid0}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ack", {28'd0, ack0}, 32'h2);
        chk("post_rst_gid", {30'd0, gid0}, 32'd1);
        chk("post_rst_bus", {24'd0, bus0}, 32'hA5);
        $display("reset abort: regrant ack=%b gid=%0d bus=%h", ack0, gid0, bus0);
        req0 = '0;
        wait_idle("abort_idle");

        // All requesters held: scoreboard of expected grant order
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
`ifdef DSA_FIXED_PRIO_EN
            exp_q.push_back(0);
`else
            exp_q.push_back(k % 4);
`endif
        end
        req0     = 4'b1111;
        cyc      = 0;
        last     = 0;
        grants   = 0;
        prev_ack = '0;
        while (cyc < 60 && exp_q.size() > 0) begin
            @(posedge clk); #1;
            cyc++;
            if (prev_ack != 0) chk("rr_ack_width", {28'd0, ack0}, 32'd0);
            if (ack0 != 0) begin
                exp_id = exp_q.pop_front();
                chk($sformatf("rr%0d_gid", grants), {30'd0, gid0}, exp_id);
                chk($sformatf("rr%0d_ack", grants), {28'd0, ack0}, 32'd1 << exp_id);
                chk($sformatf("rr%0d_bus", grants), {24'd0, bus0}, {24'd0, slot0(exp_id)});
                chk($sformatf("rr%0d_spacing", grants), cyc - last, (grants == 0) ? 1 : 8);
                $display("rr grant %0d cyc=%0d gid=%0d ack=%b", grants, cyc, gid0, ack0);
                last = cyc;
                grants++;
            end
            prev_ack = ack0;
        end
        chk("rr_all_granted", exp_q.size(), 0);
        @(posedge clk); #1;
        chk("rr_last_ack_width", {28'd0, ack0}, 32'd0);
        req0 = '0;
        exp_q.delete();
        wait_idle("rr_idle");

        // End-to-end through the DATA_SYNC model
        words = '{8'h5A, 8'h96, 8'hE1, 8'h0F};
        order = '{0, 2, 1, 3};
        for (int k = 0; k < 4; k++) begin
            idx = order[k];
            req_data1[idx*8 +: 8] = words[k];
            req1 = 4'b0001 << idx;
            e2e_q.push_back(words[k]);
            got = 0;
            for (int c = 0; c < 40; c++) begin
                @(posedge clk); #1;
                if (ack1[idx]) begin
                    got = 1;
                    break;
                end
            end
            chk($sformatf("e2e%0d_ack", k), got, 1);
            req1 = '0;
            $display("e2e send %0d req=%0d word=%h acked=%0d", k, idx, words[k], got);
        end
        for (int c = 0; c < 400 && obs_cnt < 4; c++) @(posedge clk);
        repeat (60) @(posedge clk);
        #1;
        chk("e2e_pulse_count", obs_cnt, 4);
        for (int k = 0; k < 4 && k < obs_cnt && e2e_q.size() > 0; k++) begin
            logic [7:0] ew;
            ew = e2e_q.pop_front();
            chk($sformatf("e2e%0d_word", k), {24'd0, obs_word[k]}, {24'd0, ew});
            $display("e2e recv %0d sync_bus=%h expect=%h", k, obs_word[k], ew);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
